ex_mem_stage: RTL
=================

// Module: ex_mem_stage
// PURPOSE
//  Execute stage plus EX/MEM pipeline register. Consumes the EX_* fields held by the ID/EX register.
//  Resolves operand forwarding from MEM (internal) and WB (external), then runs the ALU or an iterative multiplier.
//  Registers result, store data, destination and control for the MEM stage.
//  Asserts EX_stall while a multiply is in progress so ID/EX and earlier stages hold.
// PARAMETERS
//  DATA_W  32  datapath width; also the number of BUSY cycles of a multiply
//  REG_W   3   register index width
//  IMM_W   8   immediate width; sign-extended to DATA_W
// PORTS
//  clk             in   1       rising-edge clock
//  rst_n           in   1       synchronous, active-low reset
//  EX_valid        in   1       ID/EX holds a real instruction (0 = bubble)
//  EX_flush        in   1       kill the instruction in EX (branch redirect)
//  EX_opcode       in   6       opcode; [3:0] = ALU function when EX_aluop=1
//  EX_regwrite, EX_memtoreg, EX_memread, EX_memwrite, EX_alusrc, EX_aluop, EX_regdist  in  1 each  control
//  EX_immediate    in   IMM_W   immediate
//  EX_rs, EX_rt, EX_rd  in  REG_W  register indices
//  EX_rd1, EX_rd2  in   DATA_W  register-file read data
//  WB_regwrite     in   1       WB stage writes a register
//  WB_dest         in   REG_W   WB destination
//  WB_data         in   DATA_W  WB write data
//  MEM_valid, MEM_regwrite, MEM_memtoreg, MEM_memread, MEM_memwrite  out  1 each  registered control
//  MEM_alu_result  out  DATA_W  registered ALU/multiply result
//  MEM_store_data  out  DATA_W  registered forwarded rt operand
//  MEM_dest        out  REG_W   registered destination (EX_rd if EX_regdist=1, else EX_rt)
//  EX_stall        out  1       hold ID/EX and upstream stages
// BEHAVIOUR
//  Reset (rst_n=0 at a clock edge): every MEM_* output is 0, the FSM goes to IDLE and EX_stall=0. An in-flight multiply is dropped.
//  Forwarding for operand A (rs) and operand B-reg (rt), highest priority first:
//    1. MEM, when MEM_valid & MEM_regwrite & !MEM_memread & MEM_dest==src & src!=0.
//    2. WB, when WB_regwrite & WB_dest==src & src!=0.
//    3. Otherwise EX_rd1/EX_rd2.
//    Register 0 is never forwarded. Load-use hazards are removed upstream.
//  Operand B = EX_alusrc ? sign-extended EX_immediate : forwarded rt. MEM_store_data is always the forwarded rt.
//  EX_aluop=0: result = A+B (address calculation).
//  EX_aluop=1, EX_opcode[3:0]:
//    0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
//    5 SLT (signed, result 0/1)
//    6 SLL by B[4:0], 7 SRL (logical) by B[4:0]
//    8 MUL (low DATA_W bits of A*B)
//    9-15 give result 0
//  All arithmetic is mod 2^DATA_W with no overflow flag.
//  Single-cycle ops: EX/MEM loads at the next edge, so latency is 1 cycle.
//  FSM IDLE/BUSY/DONE (multiply only):
//    IDLE: a valid, unflushed MUL raises EX_stall combinationally. At the edge the forwarded A and B are latched, acc=0, cnt=DATA_W, go to BUSY.
//    BUSY: EX_stall=1. Each cycle: if B[0], acc += A; then A<<=1, B>>=1, cnt--. Go to DONE when cnt reaches 1 (DATA_W BUSY cycles).
//    DONE: EX_stall=0. EX/MEM loads acc plus the held control. Go to IDLE.
//    Total stall is DATA_W+1 cycles; the MUL result reaches MEM_alu_result DATA_W+2 edges after first presentation.
//  While EX_stall=1, EX/MEM loads a bubble (all MEM_* control and MEM_valid = 0; data is don't-care).
//  Operands are latched, so WB changes during BUSY do not affect the product.
//  EX_flush=1 has highest priority after reset:
//    The EX/MEM register loads a bubble and the FSM goes to IDLE, including from BUSY or DONE.
//    EX_stall=0 in that same cycle.
//  EX_valid=0 behaves as a bubble: no FSM start, and MEM_valid=0 at the next edge.
// TESTING
//  1. Reset: rst_n=0 for 2 cycles mid-stream -> all MEM_* = 0, EX_stall=0.
//  2. ADD rs=4 (42), rt=5 (43), regdist=1, rd=6 -> next cycle MEM_alu_result=85, MEM_dest=6, MEM_regwrite=1.
//  3. Forwarding: back-to-back writes to r3 (MEM=10), WB r3=20, next op ADD r3+r3 -> 20 (MEM wins). Same case with dest r0 -> no forward.
//  4. alusrc=1, imm=8'hFC, A=10, aluop=0 -> 6. SLT A=-1, B=1 -> 1. SRL A=32'h80000000, B=31 -> 1.
//  5. MUL 7*6 -> EX_stall high exactly 33 cycles, MEM_alu_result=42; MEM_valid=0 throughout the stall.
//  6. Flush during BUSY cycle 5 -> EX_stall drops the same cycle and MEM_valid=0; the next instruction then executes normally.

Source files
------------

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - execute stage with operand forwarding, ALU, iterative multiplier and EX/MEM register
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 3,
    parameter int IMM_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              EX_valid,
    input  logic              EX_flush,
    input  logic [5:0]        EX_opcode,
    input  logic              EX_regwrite,
    input  logic              EX_memtoreg,
    input  logic              EX_memread,
    input  logic              EX_memwrite,
    input  logic              EX_alusrc,
    input  logic              EX_aluop,
    input  logic              EX_regdist,
    input  logic [IMM_W-1:0]  EX_immediate,
    input  logic [REG_W-1:0]  EX_rs,
    input  logic [REG_W-1:0]  EX_rt,
    input  logic [REG_W-1:0]  EX_rd,
    input  logic [DATA_W-1:0] EX_rd1,
    input  logic [DATA_W-1:0] EX_rd2,
    input  logic              WB_regwrite,
    input  logic [REG_W-1:0]  WB_dest,
    input  logic [DATA_W-1:0] WB_data,
    output logic              MEM_valid,
    output logic              MEM_regwrite,
    output logic              MEM_memtoreg,
    output logic              MEM_memread,
    output logic              MEM_memwrite,
    output logic [DATA_W-1:0] MEM_alu_result,
    output logic [DATA_W-1:0] MEM_store_data,
    output logic [REG_W-1:0]  MEM_dest,
    output logic              EX_stall
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [DATA_W-1:0]  mul_a_q;
    logic [DATA_W-1:0]  mul_b_q;
    logic [DATA_W-1:0]  acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               hold_regwrite_q;
    logic               hold_memtoreg_q;
    logic               hold_memread_q;
    logic               hold_memwrite_q;
    logic [DATA_W-1:0]  hold_store_q;
    logic [REG_W-1:0]   hold_dest_q;

    logic               mem_fwd_ok;
    logic [DATA_W-1:0]  fwd_a;
    logic [DATA_W-1:0]  fwd_b;
    logic [DATA_W-1:0]  imm_ext;
    logic [DATA_W-1:0]  op_b;
    logic [4:0]         shamt;
    logic [DATA_W-1:0]  alu_result;
    logic [REG_W-1:0]   dest_sel;
    logic [DATA_W-1:0]  acc_d;
    logic               is_mul;
    logic               unused_opcode_bits;

    assign unused_opcode_bits = ^EX_opcode[5:4];

    // A MEM-stage load has no data yet, so only non-load MEM results are forwarded.
    always_comb begin
        mem_fwd_ok = MEM_valid && MEM_regwrite && !MEM_memread;

        fwd_a = EX_rd1;
        if (mem_fwd_ok && (EX_rs != '0) && (MEM_dest == EX_rs)) begin
            fwd_a = MEM_alu_result;
        end else if (WB_regwrite && (EX_rs != '0) && (WB_dest == EX_rs)) begin
            fwd_a = WB_data;
        end

        fwd_b = EX_rd2;
        if (mem_fwd_ok && (EX_rt != '0) && (MEM_dest == EX_rt)) begin
            fwd_b = MEM_alu_result;
        end else if (WB_regwrite && (EX_rt != '0) && (WB_dest == EX_rt)) begin
            fwd_b = WB_data;
        end
    end

    assign imm_ext  = {{(DATA_W - IMM_W){EX_immediate[IMM_W-1]}}, EX_immediate};
    assign op_b     = EX_alusrc ? imm_ext : fwd_b;
    assign shamt    = op_b[4:0];
    assign dest_sel = EX_regdist ? EX_rd : EX_rt;

    always_comb begin
        alu_result = '0;
        if (!EX_aluop) begin
            alu_result = fwd_a + op_b;
        end else begin
            case (EX_opcode[3:0])
                4'd0: alu_result = fwd_a + op_b;
                4'd1: alu_result = fwd_a - op_b;
                4'd2: alu_result = fwd_a & op_b;
                4'd3: alu_result = fwd_a | op_b;
                4'd4: alu_result = fwd_a ^ op_b;
                4'd5: alu_result = {{(DATA_W - 1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
                4'd6: alu_result = fwd_a << shamt;
                4'd7: alu_result = fwd_a >> shamt;
                default: alu_result = '0;
            endcase
        end
    end

    assign is_mul   = EX_valid && EX_aluop && (EX_opcode[3:0] == 4'd8);
    assign acc_d    = mul_b_q[0] ? (acc_q + mul_a_q) : acc_q;
    assign EX_stall = rst_n && !EX_flush &&
                      (((state_q == S_IDLE) && is_mul) || (state_q == S_BUSY));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            mul_a_q         <= '0;
            mul_b_q         <= '0;
            acc_q           <= '0;
            cnt_q           <= '0;
            hold_regwrite_q <= 1'b0;
            hold_memtoreg_q <= 1'b0;
            hold_memread_q  <= 1'b0;
            hold_memwrite_q <= 1'b0;
            hold_store_q    <= '0;
            hold_dest_q     <= '0;
            MEM_valid       <= 1'b0;
            MEM_regwrite    <= 1'b0;
            MEM_memtoreg    <= 1'b0;
            MEM_memread     <= 1'b0;
            MEM_memwrite    <= 1'b0;
            MEM_alu_result  <= '0;
            MEM_store_data  <= '0;
            MEM_dest        <= '0;
        end else if (EX_flush) begin
            state_q      <= S_IDLE;
            MEM_valid    <= 1'b0;
            MEM_regwrite <= 1'b0;
            MEM_memtoreg <= 1'b0;
            MEM_memread  <= 1'b0;
            MEM_memwrite <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (is_mul) begin
                        state_q         <= S_BUSY;
                        mul_a_q         <= fwd_a;
                        mul_b_q         <= op_b;
                        acc_q           <= '0;
                        cnt_q           <= CNT_W'(DATA_W);
                        hold_regwrite_q <= EX_regwrite;
                        hold_memtoreg_q <= EX_memtoreg;
                        hold_memread_q  <= EX_memread;
                        hold_memwrite_q <= EX_memwrite;
                        hold_store_q    <= fwd_b;
                        hold_dest_q     <= dest_sel;
                        MEM_valid       <= 1'b0;
                        MEM_regwrite    <= 1'b0;
                        MEM_memtoreg    <= 1'b0;
                        MEM_memread     <= 1'b0;
                        MEM_memwrite    <= 1'b0;
                    end else begin
                        MEM_valid      <= EX_valid;
                        MEM_regwrite   <= EX_valid && EX_regwrite;
                        MEM_memtoreg   <= EX_valid && EX_memtoreg;
                        MEM_memread    <= EX_valid && EX_memread;
                        MEM_memwrite   <= EX_valid && EX_memwrite;
                        MEM_alu_result <= alu_result;
                        MEM_store_data <= fwd_b;
                        MEM_dest       <= dest_sel;
                    end
                end
                S_BUSY: begin
                    acc_q        <= acc_d;
                    mul_a_q      <= mul_a_q << 1;
                    mul_b_q      <= mul_b_q >> 1;
                    cnt_q        <= cnt_q - CNT_W'(1);
                    MEM_valid    <= 1'b0;
                    MEM_regwrite <= 1'b0;
                    MEM_memtoreg <= 1'b0;
                    MEM_memread  <= 1'b0;
                    MEM_memwrite <= 1'b0;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q        <= S_IDLE;
                    MEM_valid      <= 1'b1;
                    MEM_regwrite   <= hold_regwrite_q;
                    MEM_memtoreg   <= hold_memtoreg_q;
                    MEM_memread    <= hold_memread_q;
                    MEM_memwrite   <= hold_memwrite_q;
                    MEM_alu_result <= acc_q;
                    MEM_store_data <= hold_store_q;
                    MEM_dest       <= hold_dest_q;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
